dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the multi-cycle processor's data-memory strobe interface. Samples the controller's `DMRead`/`DMWrite` levels, captures address and write data, inserts a programmable number of wait states, then performs a single read or write on an internal word array. Completion is signalled with a one-cycle `Ready` pulse. Strobes that remain high after completion do not trigger a second access; a re-arm rule requires the strobes to drop first. Sits between the controller/datapath and the data store, replacing a zero-latency combinational memory.

## Interface
- `DATA_W`, 16: word width.
- `ADDR_W`, 8: address width; array depth is 2^ADDR_W words.
- `WAIT_CYCLES`, 2: wait states inserted before the access; legal range 0–15.

- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `DMRead` in 1: read request level from the controller.
- `DMWrite` in 1: write request level from the controller.
- `Addr` in ADDR_W: word address, sampled at acceptance.
- `WriteData` in DATA_W: store data, sampled at acceptance.
- `ReadData` out DATA_W: registered read result; holds its value until the next read completes.
- `Ready` out 1: one-cycle completion pulse.
- `Busy` out 1: high whenever the state is not IDLE.
- `Error` out 1: one-cycle pulse when `DMRead` and `DMWrite` are both high in IDLE while armed.
- `AccessCount` out 16: count of completed accesses; wraps from 0xFFFF to 0.

## Operation
- States: IDLE, WAIT, DONE. Reset values: state IDLE, `armed`=1, wait counter 0, `ReadData`=0, `Ready`=0, `Busy`=0, `Error`=0, `AccessCount`=0. The memory array is not reset.
- IDLE, armed, exactly one strobe high:
  - Accept the request.
  - Latch `Addr`, `WriteData` and the op (read or write).
  - Load the counter with `WAIT_CYCLES`.
  - Go to WAIT and clear `armed`.
- IDLE, armed, both strobes high:
  - No access is performed.
  - Pulse `Error` for one cycle and clear `armed`.
  - Stay in IDLE.
- IDLE, not armed: if both strobes are low this cycle, set `armed`. Otherwise hold. Re-arming takes one edge, so the earliest next acceptance is the following edge.
- WAIT, counter ≠ 0: decrement the counter.
- WAIT, counter = 0:
  - Write op: mem[addr_q] ← wdata_q.
  - Read op: `ReadData` ← mem[addr_q].
  - Increment `AccessCount`.
  - Go to DONE.
- DONE: go to IDLE on the next edge.
- `Ready` is a Moore output, high only in DONE.
- Strobe and `Addr` changes while not in IDLE are ignored; the latched values are used.
- Strobes still high when the block returns to IDLE leave it not armed. A held strobe therefore never causes a repeated access.
- A read of an address completed in the same DONE cycle as a write returns the new data. Accesses are sequential, so there are no read/write hazards.

## Timing
- Accept edge E0. `Busy` is high from E0. Access is performed at edge E(WAIT_CYCLES+1). `Ready` and the new `ReadData` are valid from E(WAIT_CYCLES+1) to E(WAIT_CYCLES+2). `Busy` drops at E(WAIT_CYCLES+2).
- With `WAIT_CYCLES`=0, `Ready` is high in the cycle after acceptance.
- The minimum issue interval for back-to-back accesses is `WAIT_CYCLES`+4 edges: accept, waits, access, DONE→IDLE, one low-strobe re-arm edge, then accept.
- `Error` is high for exactly one cycle following the sampling edge.
- Reset asserted at any time:
  - Outputs take their reset values immediately, without waiting for a clock edge.
  - An in-flight write whose access edge has not occurred is dropped and the array is unchanged.
  - After `Reset` deasserts, the block is armed and IDLE.

## Test plan
- `WAIT_CYCLES`=2: write 0xBEEF to addr 0x12 (`DMWrite` for one cycle), then read 0x12. Each `Ready` rises 3 edges after acceptance, `ReadData`=0xBEEF, `AccessCount`=2.
- Hold `DMRead` high for 20 cycles on addr 0x05. Exactly one `Ready` pulse occurs and `AccessCount` increments by 1. Drop the strobe for one cycle and raise it again: a second access is accepted.
- Assert both strobes in IDLE. `Error` pulses for one cycle, `Busy` stays 0, the array is unchanged and `AccessCount` is unchanged.
- Start a write of 0x1234 to addr 0x40 (old value 0x0000) and assert `Reset` during WAIT. Outputs clear immediately. A subsequent read of 0x40 returns 0x0000.
- `WAIT_CYCLES`=0: run back-to-back read/write/read separated by one low-strobe cycle each. `Ready` appears one edge after each acceptance with correct data.
- Preload `AccessCount` to 0xFFFF (force) and complete one access. `AccessCount`=0x0000.

Source files
------------

// File: rtl/dmem_responder.sv
// Purpose: data-memory responder for the strobe interface; one read or write per request, after WAIT_CYCLES wait states.
// Latency: Ready pulses WAIT_CYCLES+1 edges after acceptance. Busy drops one edge later.
// Backpressure: only one access is in flight. Strobes are ignored while busy, and a held strobe must drop before the next accept.
// Ports: Clk, Reset (async, active-high) | DMRead, DMWrite, Addr, WriteData (request levels)
//        ReadData (registered result), Ready (done pulse), Busy, Error (both strobes), AccessCount
module dmem_responder #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              DMRead,
   input  logic              DMWrite,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData,
   output logic              Ready,
   output logic              Busy,
   output logic              Error,
   output logic [15:0]       AccessCount
);

   localparam int         DEPTH   = 1 << ADDR_W;
   localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                armed_q, armed_d;
   logic [3:0]          wcnt_q,  wcnt_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                wr_op_q, wr_op_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q,   err_d;
   logic [15:0]         cnt_q,   cnt_d;
   logic                mem_we;

   // Word store. It is deliberately not reset.
   logic [DATA_W-1:0]   mem_q [0:DEPTH-1];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         armed_q <= 1'b1;
         wcnt_q  <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_op_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_op_q <= wr_op_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      armed_d = armed_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_op_d = wr_op_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (armed_q) begin
               if (DMRead && DMWrite) begin
                  // Conflicting request: flag it and wait for the strobes to drop.
                  err_d   = 1'b1;
                  armed_d = 1'b0;
               end else if (DMRead || DMWrite) begin
                  addr_d  = Addr;
                  wdata_d = WriteData;
                  wr_op_d = DMWrite;
                  wcnt_d  = WAIT_LD;
                  armed_d = 1'b0;
                  state_d = S_WAIT;
               end
            end else if (!DMRead && !DMWrite) begin
               // Re-arm only after one edge with both strobes low, so a held strobe cannot repeat the access.
               armed_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (wcnt_q != 4'd0) begin
               wcnt_d = wcnt_q - 4'd1;
            end else begin
               mem_we = wr_op_q;
               if (!wr_op_q) begin
                  rdata_d = mem_q[addr_q];
               end
               cnt_d   = cnt_q + 16'd1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // mem_we comes from the async-reset state register. A reset that lands before the access edge therefore suppresses the write.
   always_ff @(posedge Clk) begin
      if (mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign ReadData    = rdata_q;
   assign Ready       = (state_q == S_DONE);
   assign Busy        = (state_q != S_IDLE);
   assign Error       = err_q;
   assign AccessCount = cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: self-checking bench for dmem_responder, covering one instance with 2 wait states and one with 0.
// Latency: the model predicts outputs from edge arithmetic relative to the acceptance edge.
// Backpressure: the stimulus respects the re-arm rule except where it deliberately holds strobes high.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rd   [2];
   logic        wr   [2];
   logic [7:0]  addr [2];
   logic [15:0] wd   [2];

   logic [15:0] rdata_a, rdata_b, acnt_a, acnt_b;
   logic        rdy_a, rdy_b, busy_a, busy_b, err_a, err_b;

   logic [15:0] rdata_s [2];
   logic [15:0] acnt_s  [2];
   logic        rdy_s   [2];
   logic        busy_s  [2];
   logic        err_s   [2];

   always_comb begin
      rdata_s[0] = rdata_a;  rdata_s[1] = rdata_b;
      acnt_s[0]  = acnt_a;   acnt_s[1]  = acnt_b;
      rdy_s[0]   = rdy_a;    rdy_s[1]   = rdy_b;
      busy_s[0]  = busy_a;   busy_s[1]  = busy_b;
      err_s[0]   = err_a;    err_s[1]   = err_b;
   end

   dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
      .Clk(clk), .Reset(rst), .DMRead(rd[0]), .DMWrite(wr[0]), .Addr(addr[0]),
      .WriteData(wd[0]), .ReadData(rdata_a), .Ready(rdy_a), .Busy(busy_a),
      .Error(err_a), .AccessCount(acnt_a)
   );

   dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
      .Clk(clk), .Reset(rst), .DMRead(rd[1]), .DMWrite(wr[1]), .Addr(addr[1]),
      .WriteData(wd[1]), .ReadData(rdata_b), .Ready(rdy_b), .Busy(busy_b),
      .Error(err_b), .AccessCount(acnt_b)
   );

   function automatic int wt(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic cmp(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] t=%0t got %h want %h", nm, i, $time, act, exp);
      end
   endtask

   // Transaction-level model. It records each request's acceptance edge and derives the outputs from edge offsets.
   int          cyc = 0;
   int          acc_e   [2];
   int          err_e   [2];
   bit          armed_m [2];
   bit          op_wr   [2];
   logic [7:0]  op_a    [2];
   logic [15:0] op_d    [2];
   logic [15:0] mem_m   [2][256];
   bit          known   [2][256];
   logic [15:0] e_rdata [2];
   logic [15:0] e_cnt   [2];
   bit          e_rdy [2], e_busy [2], e_err [2], e_rd_known [2];

   initial forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            acc_e[i] = -1; err_e[i] = -1; armed_m[i] = 1'b1;
            e_rdata[i] = 16'h0; e_rd_known[i] = 1'b1; e_cnt[i] = 16'h0;
         end else if (acc_e[i] >= 0 && cyc <= acc_e[i] + wt(i) + 2) begin
            if (cyc == acc_e[i] + wt(i) + 1) begin
               if (op_wr[i]) begin
                  mem_m[i][op_a[i]] = op_d[i];
                  known[i][op_a[i]] = 1'b1;
               end else begin
                  e_rdata[i]    = mem_m[i][op_a[i]];
                  e_rd_known[i] = known[i][op_a[i]];
               end
               e_cnt[i] = e_cnt[i] + 16'd1;
            end
         end else if (armed_m[i] && rd[i] && wr[i]) begin
            err_e[i] = cyc; armed_m[i] = 1'b0;
         end else if (armed_m[i] && (rd[i] || wr[i])) begin
            acc_e[i] = cyc; op_wr[i] = wr[i]; op_a[i] = addr[i]; op_d[i] = wd[i];
            armed_m[i] = 1'b0;
         end else if (!armed_m[i] && !rd[i] && !wr[i]) begin
            armed_m[i] = 1'b1;
         end
         e_busy[i] = (acc_e[i] >= 0) && (cyc < acc_e[i] + wt(i) + 2);
         e_rdy[i]  = (acc_e[i] >= 0) && (cyc == acc_e[i] + wt(i) + 1);
         e_err[i]  = (err_e[i] == cyc);
      end
   end

   initial forever begin
      @(negedge clk);
      if (cyc > 0) begin
         for (int i = 0; i < 2; i++) begin
            cmp("Ready", i, {15'd0, rdy_s[i]}, {15'd0, e_rdy[i]});
            cmp("Busy", i, {15'd0, busy_s[i]}, {15'd0, e_busy[i]});
            cmp("Error", i, {15'd0, err_s[i]}, {15'd0, e_err[i]});
            cmp("AccessCount", i, acnt_s[i], e_cnt[i]);
            if (e_rd_known[i]) cmp("ReadData", i, rdata_s[i], e_rdata[i]);
         end
      end
   end

   // Waits out the re-arm window, drives a one-cycle request and measures the edges until Ready.
   task automatic acc(input int i, input bit w, input logic [7:0] a, input logic [15:0] d,
                      input int exp_lat, output int lat);
      repeat (3) @(negedge clk);
      #1;
      rd[i] = !w; wr[i] = w; addr[i] = a; wd[i] = d;
      lat = -1;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin rd[i] = 1'b0; wr[i] = 1'b0; end
         if (rdy_s[i]) lat = k;
      end
      cmp("ready_latency", i, lat[15:0], exp_lat[15:0]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "bench did not finish");
   end

   initial begin
      int lat;
      int pulses;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 8'h0; wd[i] = 16'h0;
      end
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      cmp("rst_busy", 0, {15'd0, busy_s[0]}, 16'h0);
      cmp("rst_ready", 0, {15'd0, rdy_s[0]}, 16'h0);
      cmp("rst_count", 0, acnt_s[0], 16'h0);
      cmp("rst_rdata", 0, rdata_s[0], 16'h0);

      // Write then read back through the 2-wait-state instance.
      acc(0, 1'b1, 8'h12, 16'hBEEF, 3, lat);
      acc(0, 1'b0, 8'h12, 16'h0000, 3, lat);
      cmp("rd_beef", 0, rdata_s[0], 16'hBEEF);
      cmp("count_2", 0, acnt_s[0], 16'd2);

      // A held read produces a single access. One low cycle re-arms the block.
      acc(0, 1'b1, 8'h05, 16'h0A5A, 3, lat);
      repeat (3) @(negedge clk); #1;
      rd[0] = 1'b1; addr[0] = 8'h05;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (rdy_s[0]) pulses++;
      end
      cmp("held_pulses", 0, pulses[15:0], 16'd1);
      cmp("held_count", 0, acnt_s[0], 16'd4);
      cmp("held_rdata", 0, rdata_s[0], 16'h0A5A);
      rd[0] = 1'b0;
      @(posedge clk); #1;
      rd[0] = 1'b1;
      lat = -1;
      for (int k = 0; k < 20 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (k == 0) rd[0] = 1'b0;
         if (rdy_s[0]) lat = k;
      end
      rd[0] = 1'b0;
      cmp("rearm_latency", 0, lat[15:0], 16'd3);
      cmp("rearm_count", 0, acnt_s[0], 16'd5);

      // Both strobes together raise Error and perform no access.
      repeat (3) @(negedge clk); #1;
      rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h12; wd[0] = 16'h0000;
      @(posedge clk); #1;
      cmp("err_pulse", 0, {15'd0, err_s[0]}, 16'h1);
      cmp("err_busy", 0, {15'd0, busy_s[0]}, 16'h0);
      @(posedge clk); #1;
      cmp("err_one_cycle", 0, {15'd0, err_s[0]}, 16'h0);
      repeat (3) @(posedge clk); #1;
      rd[0] = 1'b0; wr[0] = 1'b0;
      cmp("err_count", 0, acnt_s[0], 16'd5);
      acc(0, 1'b0, 8'h12, 16'h0000, 3, lat);
      cmp("err_mem_kept", 0, rdata_s[0], 16'hBEEF);

      // A reset during WAIT drops the pending write.
      acc(0, 1'b1, 8'h40, 16'h0000, 3, lat);
      repeat (3) @(negedge clk); #1;
      wr[0] = 1'b1; addr[0] = 8'h40; wd[0] = 16'h1234;
      @(posedge clk); #1;
      wr[0] = 1'b0;
      cmp("pre_rst_busy", 0, {15'd0, busy_s[0]}, 16'h1);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      cmp("async_busy", 0, {15'd0, busy_s[0]}, 16'h0);
      cmp("async_count", 0, acnt_s[0], 16'h0);
      cmp("async_rdata", 0, rdata_s[0], 16'h0);
      cmp("async_ready", 0, {15'd0, rdy_s[0]}, 16'h0);
      @(negedge clk); #1;
      rst = 1'b0;
      acc(0, 1'b0, 8'h40, 16'h0000, 3, lat);
      cmp("dropped_write", 0, rdata_s[0], 16'h0000);
      cmp("post_rst_count", 0, acnt_s[0], 16'd1);

      // The access counter wraps from 0xFFFF to 0.
      repeat (2) @(negedge clk); #1;
      force dut_a.cnt_q = 16'hFFFF;
      e_cnt[0] = 16'hFFFF;
      #1 release dut_a.cnt_q;
      cmp("forced_count", 0, acnt_s[0], 16'hFFFF);
      acc(0, 1'b0, 8'h12, 16'h0000, 3, lat);
      cmp("wrap_count", 0, acnt_s[0], 16'h0000);

      // Zero-wait instance at the minimum issue interval.
      acc(1, 1'b1, 8'h33, 16'h5555, 1, lat);
      acc(1, 1'b0, 8'h33, 16'h0000, 1, lat);
      cmp("w0_rd1", 1, rdata_s[1], 16'h5555);
      acc(1, 1'b1, 8'h33, 16'hAAAA, 1, lat);
      acc(1, 1'b0, 8'h33, 16'h0000, 1, lat);
      cmp("w0_rd2", 1, rdata_s[1], 16'hAAAA);
      cmp("w0_count", 1, acnt_s[1], 16'd4);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
